// File: rtl/xor_parity_sched_if.sv
// Requester-side bundle for xor_parity_sched: per-requester req/word in,
// one-hot ack plus shared result and status out.
interface xor_parity_sched_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
);
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] data_in;
  logic [N-1:0]        ack;
  logic                done;
  logic                parity_out;
  logic [ID_W-1:0]     gnt_id;
  logic                busy;

  modport master (output req, data_in, input ack, done, parity_out, gnt_id, busy);
  modport slave  (input req, data_in, output ack, done, parity_out, gnt_id, busy);
endinterface

// File: rtl/xor_parity_sched.sv
// Round-robin scheduler that time-shares one bit-serial XOR stage among N
// requesters; each job takes DATA_W RUN cycles plus one DONE cycle.
module xor_parity_sched #(
  parameter int N          = 4,
  parameter int DATA_W     = 8,
  parameter int ID_W       = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               rst,
  xor_parity_sched_if.slave  bus
);
  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic            ODD   = (PARITY_ODD != 0);
  localparam logic [ID_W:0]   N_W   = (ID_W+1)'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr, r_gnt_id, w_winner;
  logic [ID_W:0]       w_sum;
  logic                w_any_req;
  logic [DATA_W-1:0]   w_word, r_shift;
  logic                r_acc, r_parity;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_last_bit;
  logic [N-1:0]        w_ack;
  logic                w_done, w_busy;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W-1));

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_winner  = r_rr_ptr;
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int i = N-1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_sum >= N_W) w_sum = w_sum - N_W;
      if (bus.req[w_sum[ID_W-1:0]]) begin
        w_winner  = w_sum[ID_W-1:0];
        w_any_req = 1'b1;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == ID_W'(i)) w_word = bus.data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    w_done      = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: if (w_any_req) w_state_nxt = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last_bit) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_ack       = N'(1) << r_gnt_id;
        w_state_nxt = IDLE;
      end
      // NOTE: the unused encoding recovers to IDLE rather than locking up.
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_shift  <= '0;
      r_acc    <= 1'b0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_any_req) begin
          r_gnt_id <= w_winner;
          r_shift  <= w_word;
          r_acc    <= 1'b0;
          r_cnt    <= '0;
        end
        RUN: begin
          r_acc   <= r_acc ^ r_shift[0];
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Result is registered on the edge that consumes the last bit, so it is stable throughout DONE.
          if (w_last_bit) r_parity <= r_acc ^ r_shift[0] ^ ODD;
        end
        DONE: r_rr_ptr <= (r_gnt_id == ID_W'(N-1)) ? '0 : r_gnt_id + ID_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.ack        = w_ack;
  assign bus.done       = w_done;
  assign bus.busy       = w_busy;
  assign bus.gnt_id     = r_gnt_id;
  assign bus.parity_out = r_parity;
endmodule

// File: tb/tb_xor_parity_sched.sv
// Self-checking bench: an even-parity and an odd-parity instance share the
// same stimulus and are compared every cycle against a job-level model.
module tb_xor_parity_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_parity_sched_if #(.N(N), .DATA_W(DW), .ID_W(IW)) bus_e ();
  xor_parity_sched_if #(.N(N), .DATA_W(DW), .ID_W(IW)) bus_o ();
  assign bus_o.req     = bus_e.req;
  assign bus_o.data_in = bus_e.data_in;

  xor_parity_sched #(.N(N), .DATA_W(DW), .ID_W(IW), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .bus(bus_e));
  xor_parity_sched #(.N(N), .DATA_W(DW), .ID_W(IW), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .bus(bus_o));

  int   checks = 0;
  int   failures = 0;
  int   model_ptr = 0;
  int   model_gnt = 0;
  logic model_par = 1'b0;
  logic model_has_job = 1'b0;

  typedef struct {
    int            id;
    logic [DW-1:0] word;
    logic          exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_obs();
    return {14'd0, bus_e.ack, bus_e.done, bus_e.busy, bus_e.gnt_id, bus_e.parity_out,
                   bus_o.ack, bus_o.done, bus_o.busy, bus_o.gnt_id, bus_o.parity_out};
  endfunction

  function automatic logic [31:0] exp_obs(input logic [N-1:0] a, input logic b,
                                          input logic [IW-1:0] g, input logic pe, input logic po);
    return {14'd0, a, |a, b, g, pe, a, |a, b, g, po};
  endfunction

  function automatic logic odd_par();
    return model_has_job ? ~model_par : 1'b0;
  endfunction

  task automatic model_reset();
    model_ptr = 0;
    model_gnt = 0;
    model_par = 1'b0;
    model_has_job = 1'b0;
  endtask

  // Entered and left at posedge+1. All requesters in mask raise req together,
  // each drops it the cycle after its own ack. Order comes from the
  // round-robin rule, timing from the DATA_W+2 cycle job period.
  task automatic run_batch(input string name, input logic [N-1:0] mask,
                           input logic [DW-1:0] w [N], input bit mid_job_events);
    int            order[$];
    logic [N-1:0]  pend;
    logic [N-1:0]  eack;
    logic          ebusy;
    int            p, len, drop, eg, job;
    pend = mask;
    p = model_ptr;
    while (pend != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (p + k) % N;
        if (pend[idx]) begin
          order.push_back(idx);
          pend[idx] = 1'b0;
          p = (idx + 1) % N;
          break;
        end
      end
    end
    len = order.size();
    for (int i = 0; i < N; i++) bus_e.data_in[i*DW +: DW] = w[i];
    bus_e.req = mask;
    for (int n = 1; n <= 10*len + 2; n++) begin
      @(negedge clk);
      eack  = '0;
      ebusy = (n >= 2) && (n % 10 != 1) && (n <= 10*len);
      if (n % 10 == 0) begin
        eack = N'(1) << order[n/10 - 1];
        model_par = ^w[order[n/10 - 1]];
        model_has_job = 1'b1;
      end
      if (n >= 2) begin
        job = (n - 2) / 10;
        if (job > len - 1) job = len - 1;
        eg = order[job];
      end else begin
        eg = model_gnt;
      end
      check(name, pack_obs(), exp_obs(eack, ebusy, IW'(eg), model_par, odd_par()));
      drop = (n % 10 == 0) ? order[n/10 - 1] : -1;
      @(posedge clk);
      #1;
      if (drop >= 0) bus_e.req[drop] = 1'b0;
      if (mid_job_events && (n % 10 == 2)) begin
        bus_e.req[order[(n-2)/10]] = 1'b0;
        bus_e.data_in[order[(n-2)/10]*DW +: DW] = '1;
      end
    end
    model_gnt = order[len-1];
    model_ptr = (order[len-1] + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[8];
    logic [DW-1:0] wa [N];

    vecs[0] = '{1, 8'hB5, 1'b1};
    vecs[1] = '{0, 8'h00, 1'b0};
    vecs[2] = '{3, 8'h80, 1'b1};
    vecs[3] = '{2, 8'h01, 1'b1};
    vecs[4] = '{2, 8'hFF, 1'b0};
    vecs[5] = '{0, 8'h7E, 1'b0};
    vecs[6] = '{1, 8'h03, 1'b0};
    vecs[7] = '{3, 8'hA7, 1'b1};

    bus_e.req = '0;
    bus_e.data_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Idle after reset: everything stays zero.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("reset_idle", pack_obs(), exp_obs('0, 1'b0, '0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end

    // Single jobs from the vector table, including odd-mode words 00 and 80.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) wa[i] = 8'h5C;
      wa[vecs[v].id] = vecs[v].word;
      run_batch("single_job", N'(1) << vecs[v].id, wa, 1'b0);
      check("table_parity", {30'd0, bus_e.parity_out, bus_o.parity_out},
            {30'd0, vecs[v].exp_par, ~vecs[v].exp_par});
    end

    // Fairness from rr_ptr=0 with all four requesting.
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    wa = '{8'h00, 8'h01, 8'h03, 8'h07};
    run_batch("round_robin", 4'b1111, wa, 1'b0);

    // After serving requester 2 the pointer sits at 3; 0 must then beat 1.
    wa = '{8'h11, 8'h13, 8'h5A, 8'h00};
    run_batch("serve_two", 4'b0100, wa, 1'b0);
    run_batch("wrap_ptr", 4'b0011, wa, 1'b0);

    // req dropped and data_in forced to FF during RUN: parity still of 01.
    wa = '{8'h00, 8'h00, 8'h01, 8'h00};
    run_batch("mid_job_drop", 4'b0100, wa, 1'b1);

    // Reset at cnt=4 aborts without ack; the held request restarts afterwards.
    bus_e.data_in[3*DW +: DW] = 8'h07;
    bus_e.req = 4'b1000;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("mid_job_running", {31'd0, bus_e.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_job_reset", pack_obs(), exp_obs('0, 1'b0, '0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", pack_obs(), exp_obs('0, 1'b0, '0, 1'b0, 1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    wa = '{8'h00, 8'h00, 8'h00, 8'h07};
    run_batch("restart_after_reset", 4'b1000, wa, 1'b0);

    // Random batches against the job-level model.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) wa[i] = DW'($urandom);
      run_batch("random", N'($urandom_range(1, (1 << N) - 1)), wa, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
